stark_wb_arbiter: RTL

Writeback arbiter directly upstream of the 4-write-port physical register file. It accepts results from NSRC functional units, buffers each source in a small FIFO, and each cycle drives up to four register-file write ports with registered outputs. It guarantees that no two ports write the same physical register in one cycle. Writes to preg 0 and writes with all-zero enables are discarded.

---
 rtl/stark_wb_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/stark_wb_arbiter.sv
// stark_wb_arbiter: writeback arbiter in front of the 4-write-port physical
// register file. Each source has a small FIFO. Every cycle the heads are scanned
// round-robin and up to four writes with distinct pregs go out on registered
// ports. Heads that write preg 0 or carry no enables are discarded.
module stark_wb_arbiter #(
   parameter int NSRC = 6,
   parameter int FDEP = 4,
   parameter int WID  = 64,
   parameter int PRB  = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NSRC-1:0]           src_valid,
   output logic [NSRC-1:0]           src_ready,
   input  logic [NSRC*PRB-1:0]       src_preg,
   input  logic [NSRC*(WID/8+1)-1:0] src_we,
   input  logic [NSRC*WID-1:0]       src_val,
   input  logic [NSRC-1:0]           src_tag,
   input  logic                      wb_stall,
   output logic [3:0]                wr,
   output logic [4*(WID/8+1)-1:0]    we,
   output logic [4*PRB-1:0]          wa,
   output logic [4*WID-1:0]          wd,
   output logic [3:0]                wt,
   output logic                      busy
);
   localparam int BEW = WID/8 + 1;
   localparam int AW  = $clog2(FDEP);
   localparam int RRW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int NP  = 4;

   // FIFO storage and pointers (one extra pointer bit separates full from empty)
   logic [PRB-1:0]          r_mpreg [NSRC][FDEP];
   logic [BEW-1:0]          r_mwe   [NSRC][FDEP];
   logic [WID-1:0]          r_mval  [NSRC][FDEP];
   logic [FDEP-1:0]         r_mtag  [NSRC];
   logic [AW:0]             r_wp    [NSRC];
   logic [AW:0]             r_rp    [NSRC];
   logic [RRW-1:0]          r_rr;
   logic [NP-1:0]           r_wr;
   logic [NP-1:0][BEW-1:0]  r_we;
   logic [NP-1:0][PRB-1:0]  r_wa;
   logic [NP-1:0][WID-1:0]  r_wd;
   logic [NP-1:0]           r_wt;
   logic                    r_busy;

   logic [NSRC-1:0]         w_empty, w_full, w_push, w_pop, w_drop, w_htag;
   logic [PRB-1:0]          w_in_preg [NSRC];
   logic [BEW-1:0]          w_in_we   [NSRC];
   logic [WID-1:0]          w_in_val  [NSRC];
   logic [PRB-1:0]          w_hpreg   [NSRC];
   logic [BEW-1:0]          w_hwe     [NSRC];
   logic [WID-1:0]          w_hval    [NSRC];
   logic [AW:0]             w_wp_nxt  [NSRC];
   logic [AW:0]             w_rp_nxt  [NSRC];
   logic [NP-1:0]           w_gnt_v;
   logic [RRW-1:0]          w_gnt_src [NP];
   logic [PRB-1:0]          w_gpreg   [NP];
   logic [2:0]              w_cnt;
   logic [RRW:0]            w_sum;
   logic [RRW-1:0]          w_idx, w_last;
   logic                    w_conf, w_busy_nxt;

   genvar gs;
   generate
      for (gs = 0; gs < NSRC; gs++) begin : g_src
         assign w_in_preg[gs] = src_preg[gs*PRB +: PRB];
         assign w_in_we[gs]   = src_we[gs*BEW +: BEW];
         assign w_in_val[gs]  = src_val[gs*WID +: WID];
         assign w_empty[gs]   = (r_wp[gs] == r_rp[gs]);
         assign w_full[gs]    = (r_wp[gs][AW] != r_rp[gs][AW]) &&
                                (r_wp[gs][AW-1:0] == r_rp[gs][AW-1:0]);
         // ready is purely !full; a same-cycle pop does not open a slot
         assign src_ready[gs] = rst_n & ~w_full[gs];
         assign w_push[gs]    = src_valid[gs] & src_ready[gs];
         assign w_hpreg[gs]   = r_mpreg[gs][r_rp[gs][AW-1:0]];
         assign w_hwe[gs]     = r_mwe[gs][r_rp[gs][AW-1:0]];
         assign w_hval[gs]    = r_mval[gs][r_rp[gs][AW-1:0]];
         assign w_htag[gs]    = r_mtag[gs][r_rp[gs][AW-1:0]];
         assign w_drop[gs]    = ~w_empty[gs] & ((w_hpreg[gs] == '0) | (w_hwe[gs] == '0));
         assign w_wp_nxt[gs]  = r_wp[gs] + (AW+1)'(w_push[gs]);
         assign w_rp_nxt[gs]  = r_rp[gs] + (AW+1)'(w_pop[gs]);
      end
   endgenerate

   // rotate-scan from rr: drops always pop, issuable heads fill ports in order
   always_comb begin
      w_pop   = '0;
      w_gnt_v = '0;
      w_cnt   = '0;
      w_sum   = '0;
      w_idx   = '0;
      w_last  = r_rr;
      w_conf  = 1'b0;
      for (int p = 0; p < NP; p++) begin
         w_gnt_src[p] = '0;
         w_gpreg[p]   = '0;
      end
      if (!wb_stall) begin
         for (int k = 0; k < NSRC; k++) begin
            w_sum = {1'b0, r_rr} + (RRW+1)'(k);
            if (w_sum >= (RRW+1)'(NSRC))
               w_sum = w_sum - (RRW+1)'(NSRC);
            w_idx  = w_sum[RRW-1:0];
            w_conf = 1'b0;
            for (int p = 0; p < NP; p++)
               if (w_gnt_v[p] && (w_gpreg[p] == w_hpreg[w_idx]))
                  w_conf = 1'b1;
            if (w_drop[w_idx]) begin
               w_pop[w_idx] = 1'b1;
            end else if (!w_empty[w_idx] && !w_cnt[2] && !w_conf) begin
               w_gnt_v[w_cnt[1:0]]   = 1'b1;
               w_gnt_src[w_cnt[1:0]] = w_idx;
               w_gpreg[w_cnt[1:0]]   = w_hpreg[w_idx];
               w_pop[w_idx]          = 1'b1;
               w_last                = w_idx;
               w_cnt                 = w_cnt + 3'd1;
            end
         end
      end
   end

   // busy reflects occupancy after this edge
   always_comb begin
      w_busy_nxt = 1'b0;
      for (int s = 0; s < NSRC; s++)
         if (w_wp_nxt[s] != w_rp_nxt[s])
            w_busy_nxt = 1'b1;
   end

   // FIFO entry storage (no reset needed, guarded by pointers)
   always_ff @(posedge clk) begin
      for (int s = 0; s < NSRC; s++) begin
         if (w_push[s]) begin
            r_mpreg[s][r_wp[s][AW-1:0]] <= w_in_preg[s];
            r_mwe[s][r_wp[s][AW-1:0]]   <= w_in_we[s];
            r_mval[s][r_wp[s][AW-1:0]]  <= w_in_val[s];
            r_mtag[s][r_wp[s][AW-1:0]]  <= src_tag[s];
         end
      end
   end

   // pointers, round-robin pointer and busy flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NSRC; s++) begin
            r_wp[s] <= '0;
            r_rp[s] <= '0;
         end
         r_rr   <= '0;
         r_busy <= 1'b0;
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            r_wp[s] <= w_wp_nxt[s];
            r_rp[s] <= w_rp_nxt[s];
         end
         if (|w_gnt_v)
            r_rr <= (w_last == RRW'(NSRC-1)) ? '0 : w_last + 1'b1;
         r_busy <= w_busy_nxt;
      end
   end

   // registered write ports; idle ports clear strobe/enables, keep addr/data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr <= '0;
         r_we <= '0;
         r_wa <= '0;
         r_wd <= '0;
         r_wt <= '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            r_wr[p] <= w_gnt_v[p];
            if (w_gnt_v[p]) begin
               r_we[p] <= w_hwe[w_gnt_src[p]];
               r_wa[p] <= w_hpreg[w_gnt_src[p]];
               r_wd[p] <= w_hval[w_gnt_src[p]];
               r_wt[p] <= w_htag[w_gnt_src[p]];
            end else begin
               r_we[p] <= '0;
            end
         end
      end
   end

   // push into a full FIFO must never happen
   always_ff @(posedge clk) begin
      if (rst_n)
         assert ((w_push & w_full) == '0);
   end

   assign wr   = r_wr;
   assign we   = r_we;
   assign wa   = r_wa;
   assign wd   = r_wd;
   assign wt   = r_wt;
   assign busy = r_busy;

endmodule
